fm_sb_freeze_mon: RTL and testbench

Freeze/init responder for the FM spybuffer bank. It consumes the per-spybuffer `freeze` vector and `init_spy_mem` request produced by the FM control block, and tracks acknowledgements from the spybuffers. It reports aggregate freeze state, per-buffer frozen masks and timeout errors back to the FM monitor registers. It also sequences the address sweep that clears spy memories. It sits between the FM AXI register block and the spybuffer instances, in the `axi_clk` domain.

---
 rtl/fm_sb_pkg.sv | 19 +
 rtl/fm_sb_init_sweep.sv | 56 +++++
 rtl/fm_sb_freeze_mon.sv | 153 +++++++++++++++
 tb/tb_fm_sb_freeze_mon.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_sb_pkg.sv
// Shared types and constants for the FM spybuffer freeze monitor.
package fm_sb_pkg;

  // Upper bound on spybuffers the monitor registers can report.
  localparam int FM_SB_MAX_N = 64;

  // Number of spybuffers mapped in the current FM build.
  localparam int sb_mapped_n = 40;

  // Freeze handshake states; encodings are visible to software via fsm_state.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FREEZING  = 3'd1,
    ST_FROZEN    = 3'd2,
    ST_RELEASING = 3'd3,
    ST_TIMEOUT   = 3'd4
  } fm_sb_mon_state_t;

endpackage

// File: rtl/fm_sb_init_sweep.sv
// Spy memory clear sequencer: rising-edge trigger, address sweep, done pulse.
module fm_sb_init_sweep #(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  output logic              busy,
  output logic              we,
  output logic [MEM_AW-1:0] addr,
  output logic              done
);

  logic              req_prev_q, req_prev_d;
  logic              busy_q, busy_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              last;

  // Next-state for the sweep: start on a fresh edge while idle, step, stop after the top address.
  always_comb begin
    req_prev_d = init_req;
    busy_d     = busy_q;
    addr_d     = addr_q;
    last       = busy_q && (addr_q == '1);
    if (busy_q) begin
      if (last) begin
        busy_d = 1'b0;
        addr_d = '0;
      end else begin
        addr_d = addr_q + MEM_AW'(1);
      end
    end else if (init_req && !req_prev_q) begin
      busy_d = 1'b1;
      addr_d = '0;
    end
  end

  // Sweep registers; reset aborts any sweep in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_prev_q <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
    end else begin
      req_prev_q <= req_prev_d;
      busy_q     <= busy_d;
      addr_q     <= addr_d;
    end
  end

  assign busy = busy_q;
  assign we   = busy_q;
  assign addr = addr_q;
  assign done = last;

endmodule

// File: rtl/fm_sb_freeze_mon.sv
// Freeze/init responder for the FM spybuffer bank (axi_clk domain).
module fm_sb_freeze_mon
  import fm_sb_pkg::*;
#(
  parameter int SB_N   = sb_mapped_n,
  parameter int TO_W   = 16,
  parameter int MEM_AW = 10
) (
  input  logic                         axi_clk,
  input  logic                         axi_reset_n,
  input  logic [SB_N-1:0]              freeze,
  input  logic [SB_N-1:0]              sb_frozen,
  input  logic                         init_spy_mem,
  input  logic [TO_W-1:0]              timeout_cycles,
  input  logic                         err_clr,
  output logic [2:0]                   fsm_state,
  output logic                         all_frozen,
  output logic                         freeze_err,
  output logic [31:0]                  frozen_mask_0,
  output logic [31:0]                  frozen_mask_1,
  output logic [$clog2(SB_N+1)-1:0]    frozen_cnt,
  output logic                         init_busy,
  output logic                         init_we,
  output logic [MEM_AW-1:0]            init_addr,
  output logic                         init_done
);

  localparam int CNT_W = $clog2(SB_N + 1);

  fm_sb_mon_state_t  state_q, state_d;
  logic [SB_N-1:0]   req_q, req_d;
  logic [SB_N-1:0]   ack_q, ack_d;
  logic [SB_N-1:0]   snap_q, snap_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic              err_q, err_d;
  logic              timeout_hit;
  logic              err_set;
  logic              entering;
  logic [FM_SB_MAX_N-1:0] ack_ext;
  logic [CNT_W-1:0]  cnt_v;

  // Handshake FSM: next state, snapshot capture, timer and sticky error.
  always_comb begin
    req_d       = freeze;
    ack_d       = sb_frozen;
    state_d     = state_q;
    snap_d      = snap_q;
    timer_d     = timer_q;
    err_set     = 1'b0;
    timeout_hit = (timeout_cycles != '0) && (timer_q == (timeout_cycles - TO_W'(1)));

    case (state_q)
      ST_IDLE: begin
        if (req_q != '0) state_d = ST_FREEZING;
      end
      ST_FREEZING: begin
        if (req_q == '0) begin
          state_d = ST_RELEASING;
        end else if ((ack_q & snap_q) == snap_q) begin
          state_d = ST_FROZEN;
        end else if (timeout_hit) begin
          state_d = ST_TIMEOUT;
          err_set = 1'b1;
        end
      end
      ST_FROZEN: begin
        if (req_q == '0) begin
          state_d = ST_RELEASING;
        end else if (req_q != snap_q) begin
          state_d = ST_FREEZING;
        end
      end
      ST_RELEASING: begin
        if (req_q != '0) begin
          state_d = ST_FREEZING;
        end else if ((ack_q & snap_q) == '0) begin
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          state_d = ST_TIMEOUT;
          err_set = 1'b1;
        end
      end
      ST_TIMEOUT: begin
        if ((req_q == '0) && (ack_q == '0)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    entering = (state_d != state_q) &&
               ((state_d == ST_FREEZING) || (state_d == ST_RELEASING));

    if ((state_d == ST_FREEZING) && (state_q != ST_FREEZING)) snap_d = req_q;

    if (entering) begin
      timer_d = '0;
    end else if (((state_q == ST_FREEZING) || (state_q == ST_RELEASING)) && (timer_q != '1)) begin
      timer_d = timer_q + TO_W'(1);
    end

    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  // State and input registers; reset returns to IDLE with every flag clear.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      ack_q   <= '0;
      snap_q  <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      snap_q  <= snap_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  // Status views of the registered acks: zero-extended masks and popcount.
  always_comb begin
    ack_ext = '0;
    ack_ext[SB_N-1:0] = ack_q;
    cnt_v = '0;
    for (int i = 0; i < SB_N; i++) begin
      cnt_v = cnt_v + CNT_W'(ack_q[i]);
    end
  end

  assign fsm_state     = state_q;
  assign all_frozen    = (state_q == ST_FROZEN);
  assign freeze_err    = err_q;
  assign frozen_mask_0 = ack_ext[31:0];
  assign frozen_mask_1 = ack_ext[63:32];
  assign frozen_cnt    = cnt_v;

  fm_sb_init_sweep #(
    .MEM_AW (MEM_AW)
  ) u_init_sweep (
    .clk      (axi_clk),
    .rst_n    (axi_reset_n),
    .init_req (init_spy_mem),
    .busy     (init_busy),
    .we       (init_we),
    .addr     (init_addr),
    .done     (init_done)
  );

endmodule

// File: tb/tb_fm_sb_freeze_mon.sv
// Scoreboard bench for fm_sb_freeze_mon: expectations are queued with a due cycle and compared on the falling edge.
module tb_fm_sb_freeze_mon;
  import fm_sb_pkg::*;

  localparam int SB_N   = 40;
  localparam int TO_W   = 16;
  localparam int MEM_AW = 4;
  localparam int CNT_W  = $clog2(SB_N + 1);

  localparam int K_STATE = 0;
  localparam int K_ALLF  = 1;
  localparam int K_ERR   = 2;
  localparam int K_MASK0 = 3;
  localparam int K_MASK1 = 4;
  localparam int K_CNT   = 5;
  localparam int K_BUSY  = 6;
  localparam int K_WE    = 7;
  localparam int K_ADDR  = 8;
  localparam int K_DONE  = 9;

  localparam logic [SB_N-1:0] ALL_ONES = 40'hFF_FFFF_FFFF;
  localparam logic [SB_N-1:0] TOP_BIT  = 40'h80_0000_0000;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic                axi_clk = 1'b0;
  logic                axi_reset_n;
  logic [SB_N-1:0]     freeze;
  logic [SB_N-1:0]     sb_frozen;
  logic                init_spy_mem;
  logic [TO_W-1:0]     timeout_cycles;
  logic                err_clr;
  logic [2:0]          fsm_state;
  logic                all_frozen;
  logic                freeze_err;
  logic [31:0]         frozen_mask_0;
  logic [31:0]         frozen_mask_1;
  logic [CNT_W-1:0]    frozen_cnt;
  logic                init_busy;
  logic                init_we;
  logic [MEM_AW-1:0]   init_addr;
  logic                init_done;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t;
  exp_t sb_q[$];

  fm_sb_freeze_mon #(
    .SB_N   (SB_N),
    .TO_W   (TO_W),
    .MEM_AW (MEM_AW)
  ) dut (
    .axi_clk        (axi_clk),
    .axi_reset_n    (axi_reset_n),
    .freeze         (freeze),
    .sb_frozen      (sb_frozen),
    .init_spy_mem   (init_spy_mem),
    .timeout_cycles (timeout_cycles),
    .err_clr        (err_clr),
    .fsm_state      (fsm_state),
    .all_frozen     (all_frozen),
    .freeze_err     (freeze_err),
    .frozen_mask_0  (frozen_mask_0),
    .frozen_mask_1  (frozen_mask_1),
    .frozen_cnt     (frozen_cnt),
    .init_busy      (init_busy),
    .init_we        (init_we),
    .init_addr      (init_addr),
    .init_done      (init_done)
  );

  // Free-running clock.
  always #5 axi_clk = ~axi_clk;

  // Cycle counter: number of rising edges seen so far.
  always @(posedge axi_clk) cyc <= cyc + 1;

  function automatic string kind_name(input int kind);
    case (kind)
      K_STATE: return "fsm_state";
      K_ALLF:  return "all_frozen";
      K_ERR:   return "freeze_err";
      K_MASK0: return "frozen_mask_0";
      K_MASK1: return "frozen_mask_1";
      K_CNT:   return "frozen_cnt";
      K_BUSY:  return "init_busy";
      K_WE:    return "init_we";
      K_ADDR:  return "init_addr";
      default: return "init_done";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_STATE: return 32'(fsm_state);
      K_ALLF:  return 32'(all_frozen);
      K_ERR:   return 32'(freeze_err);
      K_MASK0: return frozen_mask_0;
      K_MASK1: return frozen_mask_1;
      K_CNT:   return 32'(frozen_cnt);
      K_BUSY:  return 32'(init_busy);
      K_WE:    return 32'(init_we);
      K_ADDR:  return 32'(init_addr);
      default: return 32'(init_done);
    endcase
  endfunction

  function automatic void expect_at(input int due, input int kind, input logic [31:0] val);
    exp_t e;
    e.due  = due;
    e.kind = kind;
    e.val  = val;
    sb_q.push_back(e);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [SB_N-1:0] frz, input logic [SB_N-1:0] ack,
                               input logic init, input logic clr);
    freeze       = frz;
    sb_frozen    = ack;
    init_spy_mem = init;
    err_clr      = clr;
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge axi_clk);
      #1;
    end
  endtask

  // Scoreboard: on each falling edge compare and retire every expectation due this cycle.
  always @(negedge axi_clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due <= cyc) begin
        checkOutput($sformatf("%s@%0d", kind_name(sb_q[i].kind), sb_q[i].due),
                    (sb_q[i].due == cyc) ? observe(sb_q[i].kind) : 32'hDEAD_BEEF,
                    sb_q[i].val);
        sb_q.delete(i);
      end
    end
  end

  initial begin
    axi_reset_n    = 1'b0;
    timeout_cycles = 16'd100;
    applyStimulus('0, '0, 1'b0, 1'b0);

    // Reset values.
    expect_at(2, K_STATE, 0);
    expect_at(2, K_ALLF, 0);
    expect_at(2, K_ERR, 0);
    expect_at(2, K_MASK0, 0);
    expect_at(2, K_MASK1, 0);
    expect_at(2, K_CNT, 0);
    expect_at(2, K_BUSY, 0);
    expect_at(2, K_WE, 0);
    expect_at(2, K_ADDR, 0);
    expect_at(2, K_DONE, 0);
    goto(3);
    axi_reset_n = 1'b1;

    // Full freeze of all 40 buffers, acks 5 cycles after the request.
    t = cyc + 3;
    goto(t);
    applyStimulus(ALL_ONES, '0, 1'b0, 1'b0);
    expect_at(t + 1, K_STATE, 0);
    expect_at(t + 2, K_STATE, 1);
    goto(t + 5);
    applyStimulus(ALL_ONES, ALL_ONES, 1'b0, 1'b0);
    expect_at(t + 6, K_STATE, 1);
    expect_at(t + 6, K_ALLF, 0);
    expect_at(t + 6, K_CNT, 40);
    expect_at(t + 6, K_MASK0, 32'hFFFF_FFFF);
    expect_at(t + 6, K_MASK1, 32'h0000_00FF);
    expect_at(t + 7, K_STATE, 2);
    expect_at(t + 7, K_ALLF, 1);

    // Release: drop freeze, drop acks 3 cycles later.
    t = t + 10;
    goto(t);
    applyStimulus('0, ALL_ONES, 1'b0, 1'b0);
    expect_at(t + 1, K_STATE, 2);
    expect_at(t + 2, K_STATE, 3);
    expect_at(t + 2, K_ALLF, 0);
    goto(t + 3);
    applyStimulus('0, '0, 1'b0, 1'b0);
    expect_at(t + 4, K_STATE, 3);
    expect_at(t + 4, K_CNT, 0);
    expect_at(t + 5, K_STATE, 0);

    // Request change while frozen on 0x3.
    t = t + 9;
    goto(t);
    applyStimulus(40'h3, 40'h3, 1'b0, 1'b0);
    expect_at(t + 3, K_STATE, 2);
    expect_at(t + 3, K_ALLF, 1);
    goto(t + 5);
    applyStimulus(40'h7, 40'h3, 1'b0, 1'b0);
    expect_at(t + 6, K_STATE, 2);
    expect_at(t + 7, K_STATE, 1);
    expect_at(t + 7, K_ALLF, 0);
    goto(t + 8);
    applyStimulus(40'h7, 40'h7, 1'b0, 1'b0);
    expect_at(t + 9, K_STATE, 1);
    expect_at(t + 9, K_CNT, 3);
    expect_at(t + 9, K_MASK0, 32'h7);
    expect_at(t + 10, K_STATE, 2);
    expect_at(t + 10, K_ALLF, 1);
    goto(t + 12);
    applyStimulus('0, '0, 1'b0, 1'b0);
    expect_at(t + 14, K_STATE, 3);
    expect_at(t + 15, K_STATE, 0);

    // Timeout: bit 2 never acks, 10-cycle limit, then recover and clear the error.
    t = t + 18;
    goto(t);
    timeout_cycles = 16'd10;
    applyStimulus(40'hF, 40'hB, 1'b0, 1'b0);
    expect_at(t + 2, K_STATE, 1);
    expect_at(t + 11, K_STATE, 1);
    expect_at(t + 11, K_ERR, 0);
    expect_at(t + 12, K_STATE, 4);
    expect_at(t + 12, K_ERR, 1);
    expect_at(t + 12, K_ALLF, 0);
    goto(t + 14);
    applyStimulus('0, '0, 1'b0, 1'b0);
    expect_at(t + 15, K_STATE, 4);
    expect_at(t + 16, K_STATE, 0);
    expect_at(t + 16, K_ERR, 1);
    goto(t + 17);
    applyStimulus('0, '0, 1'b0, 1'b1);
    expect_at(t + 17, K_ERR, 1);
    goto(t + 18);
    applyStimulus('0, '0, 1'b0, 1'b0);
    expect_at(t + 18, K_ERR, 0);

    // Timeout disabled, plus an unrequested ack on the top buffer.
    t = t + 20;
    goto(t);
    timeout_cycles = 16'd0;
    applyStimulus(40'h1, TOP_BIT, 1'b0, 1'b0);
    expect_at(t + 1, K_CNT, 1);
    expect_at(t + 1, K_MASK0, 0);
    expect_at(t + 1, K_MASK1, 32'h80);
    expect_at(t + 2, K_STATE, 1);
    expect_at(t + 20, K_STATE, 1);
    expect_at(t + 20, K_ERR, 0);
    goto(t + 21);
    applyStimulus('0, '0, 1'b0, 1'b0);
    expect_at(t + 22, K_STATE, 1);
    expect_at(t + 23, K_STATE, 3);
    expect_at(t + 24, K_STATE, 0);

    // Init sweep over 16 addresses with a second edge ignored mid-sweep.
    t = t + 27;
    goto(t);
    applyStimulus('0, '0, 1'b1, 1'b0);
    expect_at(t, K_BUSY, 0);
    for (int k = 0; k < 16; k++) begin
      expect_at(t + 1 + k, K_ADDR, k);
      expect_at(t + 1 + k, K_WE, 1);
      expect_at(t + 1 + k, K_DONE, (k == 15) ? 1 : 0);
    end
    expect_at(t + 17, K_BUSY, 0);
    expect_at(t + 17, K_WE, 0);
    expect_at(t + 17, K_DONE, 0);
    expect_at(t + 18, K_BUSY, 0);
    expect_at(t + 20, K_BUSY, 0);
    goto(t + 2);
    applyStimulus('0, '0, 1'b0, 1'b0);
    goto(t + 5);
    applyStimulus('0, '0, 1'b1, 1'b0);
    goto(t + 7);
    applyStimulus('0, '0, 1'b0, 1'b0);

    // Reset in the middle of a sweep and a pending handshake.
    t = t + 23;
    goto(t);
    applyStimulus(40'h3, 40'h1, 1'b1, 1'b0);
    expect_at(t + 8, K_ADDR, 7);
    expect_at(t + 8, K_BUSY, 1);
    expect_at(t + 8, K_STATE, 1);
    expect_at(t + 8, K_MASK0, 1);
    goto(t + 8);
    axi_reset_n = 1'b0;
    applyStimulus('0, '0, 1'b0, 1'b0);
    expect_at(t + 9, K_STATE, 0);
    expect_at(t + 9, K_BUSY, 0);
    expect_at(t + 9, K_WE, 0);
    expect_at(t + 9, K_ADDR, 0);
    expect_at(t + 9, K_DONE, 0);
    expect_at(t + 9, K_MASK0, 0);
    expect_at(t + 9, K_CNT, 0);
    expect_at(t + 9, K_ALLF, 0);
    expect_at(t + 9, K_ERR, 0);
    goto(t + 10);
    axi_reset_n = 1'b1;
    expect_at(t + 12, K_BUSY, 0);
    expect_at(t + 12, K_DONE, 0);
    expect_at(t + 12, K_STATE, 0);

    goto(t + 15);
    checkOutput("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
